// File: rtl/norm_dispatcher_pkg.sv
// Shared types and the tag-advance rule for the dispatcher and the sorter.
package norm_dispatcher_pkg;

  localparam int unsigned TAG_SIZE = 4;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } RayDirection;

  typedef struct packed {
    logic [TAG_SIZE-1:0] tag;
    RayDirection         dir;
  } TaggedRay;

  // Thermometer tag sequence 1, 3, 7, ..., all-ones, then back to 1; never 0.
  function automatic logic [TAG_SIZE-1:0] next_tag(input logic [TAG_SIZE-1:0] tag);
    if (tag == '1) return TAG_SIZE'(1);
    return {tag[TAG_SIZE-2:0], 1'b1};
  endfunction

endpackage

// File: rtl/norm_dispatcher_if.sv
// Job handshake, divider issue bus and retire/credit signals of the dispatcher.
interface norm_dispatcher_if
  import norm_dispatcher_pkg::*;
#(
  parameter int unsigned DIV_COUNT    = 16,
  parameter int unsigned MAX_INFLIGHT = TAG_SIZE - 1
);
  localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);

  logic                 ray_valid_in;
  RayDirection          ray_in;
  logic                 ray_ready_out;
  logic [DIV_COUNT-1:0] div_ready_in;
  logic [DIV_COUNT-1:0] fifo_overflow_in;
  logic [DIV_COUNT-1:0] div_valid_out;
  TaggedRay             tagged_ray_out;
  logic                 retire_in;
  logic [IW-1:0]        inflight_out;
  logic                 retire_err_out;

  modport master (
    output ray_valid_in, ray_in, div_ready_in, fifo_overflow_in, retire_in,
    input  ray_ready_out, div_valid_out, tagged_ray_out, inflight_out, retire_err_out
  );

  modport slave (
    input  ray_valid_in, ray_in, div_ready_in, fifo_overflow_in, retire_in,
    output ray_ready_out, div_valid_out, tagged_ray_out, inflight_out, retire_err_out
  );
endinterface

// File: rtl/norm_dispatcher_rr_pick.sv
// Circular priority picker: first eligible lane at or after ptr, wrapping.
module norm_dispatcher_rr_pick #(
  parameter int unsigned N  = 16,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any
);

  // Scan lanes in order ptr, ptr+1, ... and latch onto the first eligible one.
  always_comb begin
    int unsigned j;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!any && elig[j]) begin
        any       = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/norm_dispatcher.sv
// Tags incoming ray jobs and issues them round-robin to eligible dividers,
// bounding in-flight jobs with a credit counter fed by sorter retires.
module norm_dispatcher
  import norm_dispatcher_pkg::*;
#(
  parameter int unsigned DIV_COUNT    = 16,
  parameter int unsigned MAX_INFLIGHT = TAG_SIZE - 1
) (
  input logic         clk,
  input logic         reset,
  norm_dispatcher_if.slave bus
);
  localparam int unsigned PW = $clog2(DIV_COUNT);
  localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IW-1:0] MAX_CNT  = IW'(MAX_INFLIGHT);
  localparam logic [PW-1:0] LAST_PTR = PW'(DIV_COUNT - 1);

  logic [DIV_COUNT-1:0] elig;
  logic [DIV_COUNT-1:0] grant;
  logic [PW-1:0]        grant_idx;
  logic [PW-1:0]        rr_ptr;
  logic                 any_elig;
  logic                 accept;
  logic [TAG_SIZE-1:0]  cur_tag;
  logic [IW-1:0]        inflight;

  norm_dispatcher_rr_pick #(.N(DIV_COUNT), .PW(PW)) u_pick (
    .elig      (elig),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_elig)
  );

  // Eligibility and ready are combinational so a same-cycle overflow is honoured.
  always_comb begin
    elig              = bus.div_ready_in & ~bus.fifo_overflow_in;
    bus.ray_ready_out = (inflight < MAX_CNT) & any_elig;
    accept            = bus.ray_valid_in & bus.ray_ready_out;
  end

  assign bus.inflight_out = inflight;

  // Issue register, round-robin pointer and tag advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.div_valid_out  <= '0;
      bus.tagged_ray_out <= '0;
      rr_ptr             <= '0;
      cur_tag            <= TAG_SIZE'(1);
    end else begin
      bus.div_valid_out <= accept ? grant : '0;
      if (accept) begin
        bus.tagged_ray_out <= '{tag: cur_tag, dir: bus.ray_in};
        rr_ptr             <= (grant_idx == LAST_PTR) ? '0 : grant_idx + 1'b1;
        cur_tag            <= next_tag(cur_tag);
      end
    end
  end

  // In-flight credit count; a retire with nothing in flight is flagged sticky.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight           <= '0;
      bus.retire_err_out <= 1'b0;
    end else begin
      unique case ({accept, bus.retire_in})
        2'b10: inflight <= inflight + 1'b1;
        2'b01: begin
          if (inflight == '0) bus.retire_err_out <= 1'b1;
          else                inflight <= inflight - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_dispatcher.sv
// Directed plus randomized bench for norm_dispatcher (4 lanes, 4-bit tags, 3 credits).
module tb_norm_dispatcher;
  import norm_dispatcher_pkg::*;

  localparam int N   = 4;
  localparam int MAX = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  norm_dispatcher_if #(.DIV_COUNT(N), .MAX_INFLIGHT(MAX)) bus ();

  norm_dispatcher #(.DIV_COUNT(N), .MAX_INFLIGHT(MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: tag held as a count of ones, lanes as integers.
  int          m_inf;
  int          m_ones;
  int          m_rr;
  bit          m_err;
  int          m_dv;
  logic [51:0] m_tr;

  function automatic logic [3:0] tag_of(input int ones);
    return 4'((1 << ones) - 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_inf = 0; m_ones = 1; m_rr = 0; m_err = 0; m_dv = 0; m_tr = '0;
  endtask

  task automatic chk_regs(input string pfx);
    chk({pfx, "_dv"},       64'(bus.div_valid_out),  64'(m_dv));
    chk({pfx, "_tagged"},   64'(bus.tagged_ray_out), 64'(m_tr));
    chk({pfx, "_inflight"}, 64'(bus.inflight_out),   64'(m_inf));
    chk({pfx, "_err"},      64'(bus.retire_err_out), 64'(m_err));
  endtask

  // Reset asserted between edges: registered outputs must clear immediately.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk_regs("reset_async");
    @(posedge clk); #1;
    reset = 1'b0;
    chk_regs("reset_hold");
  endtask

  // One cycle: apply inputs, check ready, clock, check registered outputs.
  task automatic drive(input bit v, input logic [47:0] r, input logic [3:0] rdy,
                       input logic [3:0] ovf, input bit ret);
    logic [3:0] elig;
    bit         exp_ready;
    bit         acc;
    int         g;
    bus.ray_valid_in     = v;
    bus.ray_in           = r;
    bus.div_ready_in     = rdy;
    bus.fifo_overflow_in = ovf;
    bus.retire_in        = ret;
    #1;
    elig      = rdy & ~ovf;
    exp_ready = (m_inf < MAX) && (elig != 0);
    chk("ready", 64'(bus.ray_ready_out), 64'(exp_ready));
    acc = v && exp_ready;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_rr + k) % N;
      if (g < 0 && elig[j]) g = j;
    end
    @(posedge clk); #1;
    if (acc) begin
      m_dv   = 1 << g;
      m_tr   = {tag_of(m_ones), r};
      m_rr   = (g + 1) % N;
      m_ones = (m_ones == 4) ? 1 : m_ones + 1;
    end else begin
      m_dv = 0;
    end
    if (acc && !ret) m_inf++;
    else if (!acc && ret) begin
      if (m_inf == 0) m_err = 1;
      else            m_inf--;
    end
    chk_regs("cycle");
  endtask

  function automatic logic [47:0] rnd48();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[47:0];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ray_valid_in = 0; bus.ray_in = '0; bus.div_ready_in = '0;
    bus.fifo_overflow_in = '0; bus.retire_in = 0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Back-to-back jobs fill the credits.
    drive(1, rnd48(), 4'hF, 4'h0, 0);
    chk("s1_dv0", 64'(bus.div_valid_out), 64'h1);
    chk("s1_tag0", 64'(bus.tagged_ray_out.tag), 64'h1);
    drive(1, rnd48(), 4'hF, 4'h0, 0);
    chk("s1_dv1", 64'(bus.div_valid_out), 64'h2);
    chk("s1_tag1", 64'(bus.tagged_ray_out.tag), 64'h3);
    drive(1, rnd48(), 4'hF, 4'h0, 0);
    chk("s1_dv2", 64'(bus.div_valid_out), 64'h4);
    chk("s1_tag2", 64'(bus.tagged_ray_out.tag), 64'h7);
    chk("s1_inflight", 64'(bus.inflight_out), 64'd3);
    chk("s1_ready_sat", 64'(bus.ray_ready_out), 64'd0);

    // Retire while saturated only reopens ready the following cycle.
    drive(1, rnd48(), 4'hF, 4'h0, 1);
    chk("s2_no_issue", 64'(bus.div_valid_out), 64'h0);
    chk("s2_ready_reopen", 64'(bus.ray_ready_out), 64'd1);
    drive(1, rnd48(), 4'hF, 4'h0, 0);
    chk("s2_dv3", 64'(bus.div_valid_out), 64'h8);
    chk("s2_tag_full", 64'(bus.tagged_ray_out.tag), 64'hF);
    drive(1, rnd48(), 4'hF, 4'h0, 1);
    drive(1, rnd48(), 4'hF, 4'h0, 0);
    chk("s2_dv_wrap", 64'(bus.div_valid_out), 64'h1);
    chk("s2_tag_wrap", 64'(bus.tagged_ray_out.tag), 64'h1);

    // Accept and retire together leave the count unchanged.
    drive(0, rnd48(), 4'hF, 4'h0, 1);
    chk("s5_pre", 64'(bus.inflight_out), 64'd2);
    drive(1, rnd48(), 4'hF, 4'h0, 1);
    chk("s5_both", 64'(bus.inflight_out), 64'd2);

    // Overflowed lanes are skipped.
    do_reset();
    drive(1, rnd48(), 4'hF, 4'h0, 0);
    drive(1, rnd48(), 4'hF, 4'h6, 0);
    chk("s3_lane3", 64'(bus.div_valid_out), 64'h8);
    drive(1, rnd48(), 4'hF, 4'h6, 0);
    chk("s3_lane0", 64'(bus.div_valid_out), 64'h1);

    // No eligible lane: no accept, tag held.
    do_reset();
    drive(1, rnd48(), 4'hF, 4'h0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, rnd48(), 4'h5, 4'h5, 0);
      chk("s4_idle", 64'(bus.div_valid_out), 64'h0);
    end
    drive(1, rnd48(), 4'hF, 4'h0, 0);
    chk("s4_lane1", 64'(bus.div_valid_out), 64'h2);
    chk("s4_held_tag", 64'(bus.tagged_ray_out.tag), 64'h3);

    // Retire underflow, then reset mid-issue.
    do_reset();
    drive(0, rnd48(), 4'hF, 4'h0, 1);
    chk("s6_err", 64'(bus.retire_err_out), 64'd1);
    chk("s6_inflight0", 64'(bus.inflight_out), 64'd0);
    drive(1, rnd48(), 4'hF, 4'h0, 0);
    drive(1, rnd48(), 4'hF, 4'h0, 0);
    chk("s6_issuing", 64'(bus.div_valid_out), 64'h2);
    do_reset();
    drive(1, rnd48(), 4'hF, 4'h0, 0);
    chk("s6_after_dv", 64'(bus.div_valid_out), 64'h1);
    chk("s6_after_tag", 64'(bus.tagged_ray_out.tag), 64'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      drive($urandom_range(0, 9) < 7, rnd48(), 4'($urandom),
            4'($urandom & $urandom & $urandom), $urandom_range(0, 9) < 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
